fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch.sv | 117 +++++++++++
 tb/tb_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction fetch stage: drives the instruction bus, follows branch and trap
// redirects, and holds the fetch->decode pipeline register.
module fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        invalidate,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  input  logic        trap_redirect,
  input  logic [31:0] trap_address,
  output logic        fetch_request,
  output logic [31:0] fetch_address,
  input  logic [31:0] fetch_data,
  input  logic        fetch_ready,
  output logic        valid_decode,
  output logic [31:0] instruction_decode,
  output logic [31:0] pc_decode,
  output logic [31:0] next_pc_decode
);

  localparam logic [31:0] NOP        = 32'h00000013;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFFFFFC;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] saved_target_reg;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        accept;
  logic [31:0] pc_plus4;

  // Redirect selection: a trap (or mret) outranks a branch arriving in the same cycle.
  assign redirect   = trap_redirect | branch_taken;
  assign target_raw = trap_redirect ? trap_address : branch_address;
  assign target     = target_raw & ALIGN_MASK;
  assign pc_plus4   = pc_reg + 32'd4;

  // In DISCARD the request stays up so the outstanding bus transaction can complete
  // and be thrown away; in FETCH a stall suppresses new requests.
  assign fetch_request = ((state_reg == FETCH) && !stall) || (state_reg == DISCARD);
  // pc_reg is kept word aligned at every update point.
  assign fetch_address = pc_reg;

  assign accept = (state_reg == FETCH) && fetch_request && fetch_ready &&
                  !redirect && !stall && !invalidate;

  // Fetch sequencing: state, program counter and the pending redirect target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      pc_reg           <= RESET_VECTOR & ALIGN_MASK;
      saved_target_reg <= 32'h00000000;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            if (fetch_request && !fetch_ready) begin
              // A transaction is in flight at the old pc; let it finish before moving.
              saved_target_reg <= target;
              state_reg        <= DISCARD;
            end else begin
              pc_reg <= target;
            end
          end else if (accept) begin
            pc_reg <= pc_plus4;
          end
        end
        DISCARD: begin
          if (redirect) begin
            saved_target_reg <= target;
          end
          if (fetch_ready) begin
            // The newest redirect wins even if it lands in the completing cycle.
            pc_reg    <= redirect ? target : saved_target_reg;
            state_reg <= FETCH;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Fetch->decode register: load on accept, otherwise bubble unless stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_decode       <= 1'b0;
      instruction_decode <= NOP;
      pc_decode          <= 32'h00000000;
      next_pc_decode     <= 32'h00000000;
    end else if (accept) begin
      valid_decode       <= 1'b1;
      instruction_decode <= fetch_data;
      pc_decode          <= pc_reg;
      next_pc_decode     <= pc_plus4;
    end else if (redirect || invalidate || !stall) begin
      valid_decode       <= 1'b0;
      instruction_decode <= NOP;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed testbench for the fetch stage. The instruction memory model returns
// the bitwise inverse of the requested address so data and pc are distinguishable.
module tb_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        invalidate;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        trap_redirect;
  logic [31:0] trap_address;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        valid_decode;
  logic [31:0] instruction_decode;
  logic [31:0] pc_decode;
  logic [31:0] next_pc_decode;

  int checks_total;
  int checks_failed;

  localparam logic [31:0] NOP = 32'h00000013;

  fetch #(.RESET_VECTOR(32'h00000000)) dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .invalidate         (invalidate),
    .branch_taken       (branch_taken),
    .branch_address     (branch_address),
    .trap_redirect      (trap_redirect),
    .trap_address       (trap_address),
    .fetch_request      (fetch_request),
    .fetch_address      (fetch_address),
    .fetch_data         (fetch_data),
    .fetch_ready        (fetch_ready),
    .valid_decode       (valid_decode),
    .instruction_decode (instruction_decode),
    .pc_decode          (pc_decode),
    .next_pc_decode     (next_pc_decode)
  );

  assign fetch_data = ~fetch_address;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) begin
      checks_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("  ok %s = %h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Check the registered decode outputs.
  task automatic check_dec(input string tag, input logic v, input logic [31:0] pc);
    check({tag, ".valid"}, {31'b0, valid_decode}, {31'b0, v});
    check({tag, ".pc"}, pc_decode, pc);
    check({tag, ".next_pc"}, next_pc_decode, pc + 32'd4);
    check({tag, ".instr"}, instruction_decode, v ? ~pc : NOP);
  endtask

  // Check the bus request after inputs have settled.
  task automatic check_bus(input string tag, input logic req, input logic [31:0] addr);
    #1;
    check({tag, ".req"}, {31'b0, fetch_request}, {31'b0, req});
    check({tag, ".addr"}, fetch_address, addr);
  endtask

  initial begin
    checks_total   = 0;
    checks_failed  = 0;
    reset          = 1'b1;
    stall          = 1'b0;
    invalidate     = 1'b0;
    branch_taken   = 1'b0;
    branch_address = 32'h0;
    trap_redirect  = 1'b0;
    trap_address   = 32'h0;
    fetch_ready    = 1'b1;

    // Reset state
    cycle();
    cycle();
    check("rst.valid", {31'b0, valid_decode}, 32'd0);
    check("rst.instr", instruction_decode, NOP);
    check("rst.pc", pc_decode, 32'h0);
    check("rst.next_pc", next_pc_decode, 32'h0);
    check_bus("rst", 1'b0, 32'h0);
    reset = 1'b0;

    // Streaming fetch with ready always high
    check_bus("idle", 1'b0, 32'h0);
    cycle();
    check_bus("first_req", 1'b1, 32'h0);
    cycle();
    check_dec("stream0", 1'b1, 32'h0);
    cycle();
    check_dec("stream4", 1'b1, 32'h4);
    cycle();
    check_dec("stream8", 1'b1, 32'h8);
    cycle();
    check_dec("streamC", 1'b1, 32'hC);

    // Wait states at 0x10
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_bus("wait", 1'b1, 32'h10);
      cycle();
      check("wait.valid", {31'b0, valid_decode}, 32'd0);
      check("wait.instr", instruction_decode, NOP);
      check("wait.pc", pc_decode, 32'hC);
    end
    fetch_ready = 1'b1;
    check_bus("wait_done", 1'b1, 32'h10);
    cycle();
    check_dec("after_wait", 1'b1, 32'h10);

    // Branch while request to 0x14 is waiting
    fetch_ready    = 1'b0;
    branch_taken   = 1'b1;
    branch_address = 32'h200;
    check_bus("br_pend", 1'b1, 32'h14);
    cycle();
    branch_taken = 1'b0;
    check_dec("br_bubble", 1'b0, 32'h10);
    check_bus("discard", 1'b1, 32'h14);
    cycle();
    check_bus("discard2", 1'b1, 32'h14);
    fetch_ready = 1'b1;
    cycle();
    check_dec("discard_drop", 1'b0, 32'h10);
    check_bus("br_target", 1'b1, 32'h200);
    cycle();
    check_dec("br_accept", 1'b1, 32'h200);

    // Simultaneous branch and trap: trap wins, response dropped
    branch_taken   = 1'b1;
    branch_address = 32'h300;
    trap_redirect  = 1'b1;
    trap_address   = 32'h80;
    cycle();
    branch_taken  = 1'b0;
    trap_redirect = 1'b0;
    check_dec("trap_bubble", 1'b0, 32'h200);
    check_bus("trap_target", 1'b1, 32'h80);
    cycle();
    check_dec("trap_accept", 1'b1, 32'h80);

    // Stall two cycles with ready high: hold, no request
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_bus("stall", 1'b0, 32'h84);
      cycle();
      check_dec("stall_hold", 1'b1, 32'h80);
    end
    stall = 1'b0;
    check_bus("stall_resume", 1'b1, 32'h84);
    cycle();
    check_dec("stall_accept", 1'b1, 32'h84);

    // Invalidate drops the response and re-requests the same word
    invalidate = 1'b1;
    cycle();
    invalidate = 1'b0;
    check_dec("inval", 1'b0, 32'h84);
    check_bus("inval_rereq", 1'b1, 32'h88);

    // Misaligned trap target near the top of memory, then wrap
    trap_redirect = 1'b1;
    trap_address  = 32'hFFFFFFFE;
    cycle();
    trap_redirect = 1'b0;
    check_bus("top_addr", 1'b1, 32'hFFFFFFFC);
    cycle();
    check("wrap.valid", {31'b0, valid_decode}, 32'd1);
    check("wrap.pc", pc_decode, 32'hFFFFFFFC);
    check("wrap.next_pc", next_pc_decode, 32'h0);
    check("wrap.instr", instruction_decode, 32'h00000003);
    check_bus("wrap_addr", 1'b1, 32'h0);

    // Asynchronous reset in DISCARD abandons the saved target
    fetch_ready    = 1'b0;
    branch_taken   = 1'b1;
    branch_address = 32'h400;
    cycle();
    branch_taken = 1'b0;
    check_bus("pre_rst_discard", 1'b1, 32'h0);
    #2;
    reset = 1'b1;
    check_bus("async_rst", 1'b0, 32'h0);
    check("async_rst.valid", {31'b0, valid_decode}, 32'd0);
    check("async_rst.pc", pc_decode, 32'h0);
    cycle();
    reset       = 1'b0;
    fetch_ready = 1'b1;
    check_bus("rst2_idle", 1'b0, 32'h0);
    cycle();
    check_bus("rst2_fetch", 1'b1, 32'h0);
    cycle();
    check_dec("rst2_accept", 1'b1, 32'h0);
    check_bus("rst2_next", 1'b1, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_total, checks_failed);
    $finish;
  end

endmodule
